// File: rtl/ucsbece154b_mem_pkg.sv
// Shared types and helpers for the data-memory responder.
//   state_t      : responder FSM states (IDLE, WAIT, RESP)
//   DMEM_BASE    : default byte address of word 0
//   LAT_W        : width of the latency wait counter (LATENCY 0..15)
//   addr_off     : byte offset of an address from the memory base
//   addr_inrange : base <= addr and word index < 2**depth_log2
package ucsbece154b_mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [31:0] DMEM_BASE = 32'h1000_0000;
  localparam int          LAT_W     = 4;

  function automatic logic [31:0] addr_off(input logic [31:0] addr,
                                           input logic [31:0] base);
    return addr - base;
  endfunction

  // The range test uses the whole 32-bit offset so large offsets cannot alias
  // onto a valid index after truncation.
  function automatic logic addr_inrange(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input int unsigned depth_log2);
    return (addr >= base) &&
           ((addr_off(addr, base) >> (depth_log2 + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/ucsbece154b_mem_array.sv
// Word storage for the data-memory responder. No reset: contents survive
// reset and power up undefined.
//   clk   : write clock (rising edge)
//   we    : write enable for the addressed word
//   be    : per-byte write enables, lane k = bits [8k+7:8k]
//   addr  : word index shared by the write port and the async read port
//   wdata : store data
//   rdata : combinational read of the addressed word
module ucsbece154b_mem_array #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] DATA [0:(2**DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (we && be[k]) DATA[addr][8*k +: 8] <= wdata[8*k +: 8];
    end
  end

  assign rdata = DATA[addr];

endmodule

// File: rtl/ucsbece154b_dmem_responder.sv
// Data-memory responder: slave end of the core's load/store port. Accepts one
// request at a time, waits LATENCY cycles, then presents a response until it
// is taken. Optional mailbox/halt word enabled by macro UCSBECE154B_TOHOST_EN.
//   clk, reset          : clock; asynchronous active-low reset
//   req_valid/req_ready : request handshake (ready only while IDLE)
//   req_we/addr/wdata/be: request fields (store, byte address, data, lanes)
//   resp_valid/ready    : response handshake
//   resp_rdata          : load data (0 for stores and errors)
//   resp_err            : out-of-range or misaligned access
//   halt, tohost_data   : mailbox outputs (0 when the feature is disabled)
module ucsbece154b_dmem_responder
  import ucsbece154b_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE,
  parameter int          DEPTH_LOG2  = 6,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] TOHOST_ADDR = 32'h1000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        halt,
  output logic [31:0] tohost_data
);

  state_t                state_q, state_d;
  logic [LAT_W-1:0]      cnt_q;
  logic                  lat_we;
  logic [31:0]           lat_addr, lat_wdata;
  logic [3:0]            lat_be;
  logic                  accept, enter_resp;
  logic                  cur_we;
  logic [31:0]           cur_addr, cur_wdata;
  logic [3:0]            cur_be;
  logic                  misaligned, in_range, is_tohost, acc_err, mem_we;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           mem_rdata, load_word;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign accept     = req_valid && req_ready;

  // With LATENCY==0 the commit happens on the accept edge itself, before the
  // latch holds anything, so the live request is used while IDLE.
  assign cur_we    = req_ready ? req_we    : lat_we;
  assign cur_addr  = req_ready ? req_addr  : lat_addr;
  assign cur_wdata = req_ready ? req_wdata : lat_wdata;
  assign cur_be    = req_ready ? req_be    : lat_be;

  assign misaligned = |cur_addr[1:0];
  assign in_range   = addr_inrange(cur_addr, BASE_ADDR, DEPTH_LOG2);
  assign is_tohost  = (cur_addr == TOHOST_ADDR);
  assign idx        = DEPTH_LOG2'(addr_off(cur_addr, BASE_ADDR) >> 2);

  always_comb begin
    state_d    = state_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == LAT_W'(1)) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) cnt_q <= LAT_W'(LATENCY);
      else if (state_q == WAIT) cnt_q <= cnt_q - LAT_W'(1);
      if (enter_resp) begin
        resp_err   <= acc_err;
        resp_rdata <= (cur_we || acc_err) ? 32'd0 : load_word;
      end else if (resp_valid && resp_ready) begin
        resp_err   <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

  // Request fields are plain data: captured on accept, never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= req_we;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
    end
  end

  // Gated by reset so a LATENCY==0 accept seen while reset is held cannot write.
  assign mem_we = enter_resp && cur_we && !acc_err && !is_tohost && reset;

  ucsbece154b_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .be    (cur_be),
    .addr  (idx),
    .wdata (cur_wdata),
    .rdata (mem_rdata)
  );

`ifdef UCSBECE154B_TOHOST_EN
  logic        halt_q;
  logic [31:0] tohost_q;

  // The mailbox takes the whole word regardless of byte enables.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halt_q   <= 1'b0;
      tohost_q <= '0;
    end else if (enter_resp && cur_we && is_tohost) begin
      tohost_q <= cur_wdata;
      if (cur_wdata[0]) halt_q <= 1'b1;
    end
  end

  assign acc_err     = !is_tohost && (misaligned || !in_range);
  assign load_word   = is_tohost ? tohost_q : mem_rdata;
  assign halt        = halt_q;
  assign tohost_data = tohost_q;
`else
  // Without the mailbox its address is refused like any unmapped address.
  assign acc_err     = misaligned || !in_range || is_tohost;
  assign load_word   = mem_rdata;
  assign halt        = 1'b0;
  assign tohost_data = '0;
`endif

endmodule
